// File: rtl/ysyx_22050710_wb_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050710_pkg : shared widths, bus layouts and field offsets     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ysyx_22050710_pkg;

  localparam int WORD_WD     = 64;
  localparam int PC_WD       = 64;
  localparam int INST_WD     = 32;
  localparam int GPR_ADDR_WD = 5;
  localparam int CSR_ADDR_WD = 12;

  localparam int MS_TO_WS_BUS_WD = 1 + GPR_ADDR_WD + WORD_WD + 1 + CSR_ADDR_WD + WORD_WD;
  localparam int DEBUG_BUS_WD    = 1 + INST_WD + PC_WD + PC_WD + 1 + WORD_WD;

  // memory-to-write-back bus, packed MSB first: {gpr_wen, rd, gpr_result, csr_wen, csr, csr_result}
  localparam int BUS_CSR_RESULT_LSB = 0;
  localparam int BUS_CSR_LSB        = BUS_CSR_RESULT_LSB + WORD_WD;
  localparam int BUS_CSR_WEN_BIT    = BUS_CSR_LSB + CSR_ADDR_WD;
  localparam int BUS_GPR_RESULT_LSB = BUS_CSR_WEN_BIT + 1;
  localparam int BUS_RD_LSB         = BUS_GPR_RESULT_LSB + WORD_WD;
  localparam int BUS_GPR_WEN_BIT    = BUS_RD_LSB + GPR_ADDR_WD;

  typedef struct packed {
    logic                  valid;
    logic [INST_WD-1:0]    inst;
    logic [PC_WD-1:0]      pc;
    logic [PC_WD-1:0]      dnpc;
    logic                  memen;
    logic [WORD_WD-1:0]    memaddr;
  } debug_bus_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050710_wb_stage_if : memory -> write-back handshake and bus   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ysyx_22050710_wb_stage_if;
  import ysyx_22050710_pkg::*;

  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [DEBUG_BUS_WD-1:0]    debug_ms_to_ws_bus;
  logic                       ws_allowin;

  modport master (
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    output debug_ms_to_ws_bus,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    input  debug_ms_to_ws_bus,
    output ws_allowin
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22050710_wb_stage_instret_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050710_instret_cnt : 64-bit retired-instruction counter       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22050710_instret_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;
  logic [63:0] cnt_d;

  // wraps silently modulo 2^64
  assign cnt_d = en_i ? (cnt_q + 64'd1) : cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 64'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_wb_stage_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050710_Reg : generic enabled register, async active-low reset |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22050710_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_o <= RESET_VAL;
    end else if (wen_i) begin
      dout_o <= din_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ysyx_22050710_wb_stage : write-back stage, GPR/CSR commit + instret  |
// | Optional difftest commit port: YSYX_22050710_DIFFTEST_EN             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ysyx_22050710_wb_stage
  import ysyx_22050710_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ysyx_22050710_wb_stage_if.slave ms_if,
  input  logic                   i_csr_port_busy,
  output logic                   o_gpr_wen,
  output logic [GPR_ADDR_WD-1:0] o_gpr_waddr,
  output logic [WORD_WD-1:0]     o_gpr_wdata,
  output logic                   o_csr_wen,
  output logic [CSR_ADDR_WD-1:0] o_csr_waddr,
  output logic [WORD_WD-1:0]     o_csr_wdata,
  output logic [GPR_ADDR_WD-1:0] o_ws_to_ds_gpr_rd,
  output logic [CSR_ADDR_WD-1:0] o_ws_to_ds_csr_rd,
  output logic                   o_retire,
  output logic [63:0]            o_instret
`ifdef YSYX_22050710_DIFFTEST_EN
  ,
  output logic                   o_commit_valid,
  output logic [PC_WD-1:0]       o_commit_pc,
  output logic [INST_WD-1:0]     o_commit_inst,
  output logic [PC_WD-1:0]       o_commit_dnpc
`endif
);

  logic                       ws_valid_q;
  logic [MS_TO_WS_BUS_WD-1:0] bus_q;
  logic                       ws_ready_go;
  logic                       ws_allowin;
  logic                       bus_load;
  logic                       fire;

  logic                   bus_gpr_wen;
  logic [GPR_ADDR_WD-1:0] bus_rd;
  logic [WORD_WD-1:0]     bus_gpr_result;
  logic                   bus_csr_wen;
  logic [CSR_ADDR_WD-1:0] bus_csr;
  logic [WORD_WD-1:0]     bus_csr_result;

  assign bus_gpr_wen    = bus_q[BUS_GPR_WEN_BIT];
  assign bus_rd         = bus_q[BUS_RD_LSB +: GPR_ADDR_WD];
  assign bus_gpr_result = bus_q[BUS_GPR_RESULT_LSB +: WORD_WD];
  assign bus_csr_wen    = bus_q[BUS_CSR_WEN_BIT];
  assign bus_csr        = bus_q[BUS_CSR_LSB +: CSR_ADDR_WD];
  assign bus_csr_result = bus_q[BUS_CSR_RESULT_LSB +: WORD_WD];

  // the trap unit wins the shared CSR write port
  assign ws_ready_go      = !(bus_csr_wen && i_csr_port_busy);
  assign ws_allowin       = !ws_valid_q || ws_ready_go;
  assign ms_if.ws_allowin = ws_allowin;
  assign bus_load         = ms_if.ms_to_ws_valid && ws_allowin;
  assign fire             = ws_valid_q && ws_ready_go;

  ysyx_22050710_Reg #(.WIDTH(1)) u_valid_reg (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .wen_i (ws_allowin),
    .din_i (ms_if.ms_to_ws_valid),
    .dout_o(ws_valid_q)
  );

  ysyx_22050710_Reg #(.WIDTH(MS_TO_WS_BUS_WD)) u_bus_reg (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .wen_i (bus_load),
    .din_i (ms_if.ms_to_ws_bus),
    .dout_o(bus_q)
  );

  assign o_gpr_wen   = fire && bus_gpr_wen && (bus_rd != '0);
  assign o_gpr_waddr = bus_rd;
  assign o_gpr_wdata = bus_gpr_result;
  assign o_csr_wen   = fire && bus_csr_wen;
  assign o_csr_waddr = bus_csr;
  assign o_csr_wdata = bus_csr_result;

  assign o_ws_to_ds_gpr_rd = (ws_valid_q && bus_gpr_wen) ? bus_rd  : '0;
  assign o_ws_to_ds_csr_rd = (ws_valid_q && bus_csr_wen) ? bus_csr : '0;

  assign o_retire = fire;

  ysyx_22050710_instret_cnt u_instret_cnt (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .en_i  (fire),
    .cnt_o (o_instret)
  );

`ifdef YSYX_22050710_DIFFTEST_EN
  logic [DEBUG_BUS_WD-1:0] dbg_q;
  debug_bus_t              dbg;
  logic                    commit_valid_q;
  logic [PC_WD-1:0]        commit_pc_q;
  logic [INST_WD-1:0]      commit_inst_q;
  logic [PC_WD-1:0]        commit_dnpc_q;
  logic                    unused_dbg;

  ysyx_22050710_Reg #(.WIDTH(DEBUG_BUS_WD)) u_dbg_reg (
    .clk_i (i_clk),
    .rst_ni(i_rst_n),
    .wen_i (bus_load),
    .din_i (ms_if.debug_ms_to_ws_bus),
    .dout_o(dbg_q)
  );

  assign dbg        = debug_bus_t'(dbg_q);
  assign unused_dbg = ^{dbg.valid, dbg.memen, dbg.memaddr};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      commit_valid_q <= 1'b0;
      commit_pc_q    <= '0;
      commit_inst_q  <= '0;
      commit_dnpc_q  <= '0;
    end else begin
      commit_valid_q <= fire;
      if (fire) begin
        commit_pc_q   <= dbg.pc;
        commit_inst_q <= dbg.inst;
        commit_dnpc_q <= dbg.dnpc;
      end
    end
  end

  assign o_commit_valid = commit_valid_q;
  assign o_commit_pc    = commit_pc_q;
  assign o_commit_inst  = commit_inst_q;
  assign o_commit_dnpc  = commit_dnpc_q;
`else
  logic unused_dbg;
  assign unused_dbg = ^ms_if.debug_ms_to_ws_bus;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_wb_stage.sv
`default_nettype none
// Self-checking bench for ysyx_22050710_wb_stage: scoreboard of expected commits.
module tb_ysyx_22050710_wb_stage;
  import ysyx_22050710_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   busy;
  logic                   gpr_wen, csr_wen, retire;
  logic [GPR_ADDR_WD-1:0] gpr_waddr, gpr_rd;
  logic [CSR_ADDR_WD-1:0] csr_waddr, csr_rd;
  logic [WORD_WD-1:0]     gpr_wdata, csr_wdata;
  logic [63:0]            instret;
`ifdef YSYX_22050710_DIFFTEST_EN
  logic                   commit_valid;
  logic [PC_WD-1:0]       commit_pc, commit_dnpc;
  logic [INST_WD-1:0]     commit_inst;
`endif

  ysyx_22050710_wb_stage_if u_if ();

  ysyx_22050710_wb_stage dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .ms_if            (u_if.slave),
    .i_csr_port_busy  (busy),
    .o_gpr_wen        (gpr_wen),
    .o_gpr_waddr      (gpr_waddr),
    .o_gpr_wdata      (gpr_wdata),
    .o_csr_wen        (csr_wen),
    .o_csr_waddr      (csr_waddr),
    .o_csr_wdata      (csr_wdata),
    .o_ws_to_ds_gpr_rd(gpr_rd),
    .o_ws_to_ds_csr_rd(csr_rd),
    .o_retire         (retire),
    .o_instret        (instret)
`ifdef YSYX_22050710_DIFFTEST_EN
    ,
    .o_commit_valid   (commit_valid),
    .o_commit_pc      (commit_pc),
    .o_commit_inst    (commit_inst),
    .o_commit_dnpc    (commit_dnpc)
`endif
  );

  typedef struct packed {
    logic        gwen;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        cwen;
    logic [11:0] caddr;
    logic [63:0] cdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [63:0] exp_instret;
  int          n_checks = 0;
  int          n_fail   = 0;

  // drives one instruction onto the bus and records the commit it must produce
  task automatic send(input logic gw, input logic [4:0] rd, input logic [63:0] gd,
                      input logic cw, input logic [11:0] csr, input logic [63:0] cd);
    logic [255:0] rnd;
    exp_t x;
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
    u_if.ms_to_ws_valid     = 1'b1;
    u_if.ms_to_ws_bus       = {gw, rd, gd, cw, csr, cd};
    u_if.debug_ms_to_ws_bus = rnd[DEBUG_BUS_WD-1:0];
    x.gwen  = gw && (rd != 5'd0);
    x.waddr = rd;
    x.wdata = gd;
    x.cwen  = cw;
    x.caddr = csr;
    x.cdata = cd;
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    busy  = 1'b0;
    u_if.ms_to_ws_valid     = 1'b0;
    u_if.ms_to_ws_bus       = '0;
    u_if.debug_ms_to_ws_bus = '0;
    exp_instret = 64'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({u_if.ws_allowin, gpr_wen, csr_wen, retire} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got allowin/gwen/cwen/retire=%b expected 1000",
               {u_if.ws_allowin, gpr_wen, csr_wen, retire});
    end
    n_checks++;
    if ({instret, gpr_rd, csr_rd} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got instret=%h gpr_rd=%h csr_rd=%h expected all 0",
               instret, gpr_rd, csr_rd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_gpr_write();
    @(posedge clk); #1;
    send(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 12'h0, 64'h0);
    @(posedge clk); #1;
    u_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({retire, gpr_wen, gpr_waddr, gpr_wdata, csr_wen} !== {1'b1, e.gwen, e.waddr, e.wdata, e.cwen}) begin
      n_fail++;
      $display("FAIL gpr_commit: got ret=%b wen=%b addr=%0d data=%h cwen=%b expected ret=1 wen=%b addr=%0d data=%h cwen=%b",
               retire, gpr_wen, gpr_waddr, gpr_wdata, csr_wen, e.gwen, e.waddr, e.wdata, e.cwen);
    end
    n_checks++;
    if (gpr_rd !== 5'd5) begin
      n_fail++;
      $display("FAIL gpr_hazard: got %0d expected 5", gpr_rd);
    end
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    n_checks++;
    if ({retire, gpr_wen, gpr_rd, instret} !== {1'b0, 1'b0, 5'd0, exp_instret}) begin
      n_fail++;
      $display("FAIL gpr_after: got ret=%b wen=%b rd=%0d instret=%0d expected 0 0 0 %0d",
               retire, gpr_wen, gpr_rd, instret, exp_instret);
    end
  endtask

  task automatic test_x0_write();
    @(posedge clk); #1;
    send(1'b1, 5'd0, 64'h1234_5678, 1'b0, 12'h0, 64'h0);
    @(posedge clk); #1;
    u_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({retire, gpr_wen, gpr_rd} !== {1'b1, e.gwen, 5'd0}) begin
      n_fail++;
      $display("FAIL x0_write: got ret=%b wen=%b hazard=%0d expected ret=1 wen=%b hazard=0",
               retire, gpr_wen, gpr_rd, e.gwen);
    end
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++;
      $display("FAIL x0_instret: got %0d expected %0d", instret, exp_instret);
    end
  endtask

  task automatic test_csr_stall();
    @(posedge clk); #1;
    send(1'b0, 5'd0, 64'h0, 1'b1, 12'h300, 64'hABCD_0123);
    busy = 1'b1;
    @(posedge clk); #1;
    u_if.ms_to_ws_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({u_if.ws_allowin, csr_rd, csr_wen, retire, instret} !== {1'b0, 12'h300, 1'b0, 1'b0, exp_instret}) begin
        n_fail++;
        $display("FAIL csr_stall[%0d]: got allowin=%b csr_rd=%h cwen=%b ret=%b instret=%0d expected 0 300 0 0 %0d",
                 k, u_if.ws_allowin, csr_rd, csr_wen, retire, instret, exp_instret);
      end
      @(posedge clk); #1;
      if (k == 2) busy = 1'b0;
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({retire, u_if.ws_allowin, csr_wen, csr_waddr, csr_wdata, gpr_wen} !== {1'b1, 1'b1, e.cwen, e.caddr, e.cdata, e.gwen}) begin
      n_fail++;
      $display("FAIL csr_commit: got ret=%b allowin=%b cwen=%b addr=%h data=%h gwen=%b expected 1 1 1 %h %h 0",
               retire, u_if.ws_allowin, csr_wen, csr_waddr, csr_wdata, gpr_wen, e.caddr, e.cdata);
    end
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    n_checks++;
    if ({retire, csr_wen, instret} !== {1'b0, 1'b0, exp_instret}) begin
      n_fail++;
      $display("FAIL csr_once: got ret=%b cwen=%b instret=%0d expected 0 0 %0d",
               retire, csr_wen, instret, exp_instret);
    end
  endtask

  task automatic test_back_to_back();
    int          sent    = 0;
    int          retired = 0;
    logic [63:0] start;
    start = exp_instret;
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      if (sent < 10) begin
        send(sent % 3 != 2, (sent % 4 == 0) ? 5'd0 : 5'(sent + 1), {32'($urandom()), 32'($urandom())},
             sent % 4 == 1, 12'(12'h340 + sent), {32'($urandom()), 32'(sent)});
        sent++;
      end else begin
        u_if.ms_to_ws_valid = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (instret !== exp_instret || u_if.ws_allowin !== 1'b1 || retire !== (c >= 1 && c <= 10)) begin
        n_fail++;
        $display("FAIL stream_cycle[%0d]: got instret=%0d allowin=%b ret=%b expected %0d 1 %b",
                 c, instret, u_if.ws_allowin, retire, exp_instret, (c >= 1 && c <= 10));
      end
      if (retire === 1'b1) begin
        retired++;
        exp_instret = exp_instret + 64'd1;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got unexpected retire expected none");
        end else begin
          e = exp_q.pop_front();
          if ({gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata} !==
              {e.gwen, e.waddr, e.wdata, e.cwen, e.caddr, e.cdata}) begin
            n_fail++;
            $display("FAIL stream_commit[%0d]: got g=%b/%0d/%h c=%b/%h/%h expected g=%b/%0d/%h c=%b/%h/%h",
                     retired, gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
                     e.gwen, e.waddr, e.wdata, e.cwen, e.caddr, e.cdata);
          end
        end
      end
    end
    n_checks++;
    if (retired != 10 || exp_q.size() != 0 || instret !== start + 64'd10) begin
      n_fail++;
      $display("FAIL stream_total: got retired=%0d left=%0d instret=%0d expected 10 0 %0d",
               retired, exp_q.size(), instret, start + 64'd10);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    force dut.u_instret_cnt.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    send(1'b1, 5'd3, 64'h55, 1'b0, 12'h0, 64'h0);
    @(posedge clk); #1;
    release dut.u_instret_cnt.cnt_q;
    u_if.ms_to_ws_valid = 1'b0;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({retire, gpr_wen, gpr_waddr, instret} !== {1'b1, e.gwen, e.waddr, exp_instret}) begin
      n_fail++;
      $display("FAIL wrap_pre: got ret=%b wen=%b addr=%0d instret=%h expected 1 1 3 %h",
               retire, gpr_wen, gpr_waddr, instret, exp_instret);
    end
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    n_checks++;
    if (instret !== exp_instret) begin
      n_fail++;
      $display("FAIL wrap: got instret=%h expected %h", instret, exp_instret);
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    send(1'b1, 5'd9, 64'h99, 1'b1, 12'h305, 64'h77);
    busy = 1'b1;
    @(posedge clk); #1;
    u_if.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({u_if.ws_allowin, gpr_rd, csr_rd} !== {1'b0, 5'd9, 12'h305}) begin
      n_fail++;
      $display("FAIL mid_hold: got allowin=%b gpr_rd=%0d csr_rd=%h expected 0 9 305",
               u_if.ws_allowin, gpr_rd, csr_rd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_instret = 64'd0;
    n_checks++;
    if ({u_if.ws_allowin, gpr_wen, csr_wen, retire, gpr_rd, csr_rd, instret} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 12'd0, exp_instret}) begin
      n_fail++;
      $display("FAIL mid_reset: got allowin=%b gwen=%b cwen=%b ret=%b gpr_rd=%0d csr_rd=%h instret=%0d expected 1 0 0 0 0 0 0",
               u_if.ws_allowin, gpr_wen, csr_wen, retire, gpr_rd, csr_rd, instret);
    end
    busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_gpr_write();
    test_x0_write();
    test_csr_stall();
    test_back_to_back();
    test_wrap();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
